// File: rtl/square_seq.sv
// Sequential shift-add squarer: Q8.8 operand in, exact Q16.16 square out, plus
// a rounded/saturated 8-bit integer view of the square.
module square_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic [7:0]  out_round,
  output logic        sat,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_next;
  logic [31:0] a;
  logic [15:0] b;
  logic [31:0] acc;
  logic [3:0]  cnt;

  logic [31:0] acc_sum;
  logic [8:0]  round_sum;
  logic        sat_next;
  logic [7:0]  round_next;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready is high only in IDLE, out_valid only in DONE.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign dbg_state = state;

  always_comb begin
    acc_sum    = b[0] ? (acc + a) : acc;
    round_sum  = {1'b0, acc_sum[23:16]} + {8'd0, acc_sum[15]};
    sat_next   = (acc_sum[31:24] != 8'd0) || round_sum[8];
    round_next = sat_next ? 8'hFF : round_sum[7:0];
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (in_valid) state_next = CALC;
      CALC: if (cnt == 4'd15) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Datapath; the result registers only load on the last CALC cycle, so they
  // hold through DONE and back in IDLE until the next result.
  always_ff @(posedge clk) begin
    if (reset) begin
      a         <= 32'd0;
      b         <= 16'd0;
      acc       <= 32'd0;
      cnt       <= 4'd0;
      out       <= 32'd0;
      out_round <= 8'd0;
      sat       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a   <= {16'd0, in};
            b   <= in;
            acc <= 32'd0;
            cnt <= 4'd0;
          end
        end
        CALC: begin
          acc <= acc_sum;
          a   <= a << 1;
          b   <= b >> 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            out       <= acc_sum;
            out_round <= round_next;
            sat       <= sat_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
